// File: rtl/ff_sub_arbiter.sv
// Round-robin arbiter that time-shares one field subtractor among NUM_REQ requesters.
// Latches the winner's operands, pulses the load, waits for done (with watchdog) and returns the result.
module ff_sub_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 256,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       rx_req,
  input  logic [NUM_REQ*WIDTH-1:0] rx_a,
  input  logic [NUM_REQ*WIDTH-1:0] rx_b,
  input  logic [WIDTH-1:0]         rx_p,
  output logic [NUM_REQ-1:0]       tx_ack,
  output logic                     tx_error,
  output logic [WIDTH-1:0]         tx_result,
  output logic                     tx_sub_start,
  output logic [WIDTH-1:0]         tx_sub_a,
  output logic [WIDTH-1:0]         tx_sub_b,
  output logic [WIDTH-1:0]         tx_sub_p,
  input  logic                     rx_sub_done,
  input  logic [WIDTH-1:0]         rx_sub_result
);

  localparam int IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WDW = $clog2(TIMEOUT + 2);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_ARM   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_grant;
  logic [WDW-1:0]  r_wd;

  logic            w_any;
  logic [IW-1:0]   w_winner;
  logic [WDW-1:0]  w_wd_next;
  logic            w_timeout;
  logic [IW-1:0]   w_ptr_next;

  // Round-robin pick: scan downward so the last hit is the first set bit at or after r_ptr.
  always_comb begin
    w_any    = 1'b0;
    w_winner = {IW{1'b0}};
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(r_ptr) + k) % NUM_REQ;
      if (rx_req[idx]) begin
        w_any    = 1'b1;
        w_winner = IW'(idx);
      end else begin
        w_any    = w_any;
        w_winner = w_winner;
      end
    end
  end

  // Watchdog increment, expiry detect and pointer advance past the current grant.
  always_comb begin
    w_wd_next = r_wd + WDW'(1);
    w_timeout = (TIMEOUT != 0) && (w_wd_next == WDW'(TIMEOUT));
    if (r_grant == IW'(NUM_REQ - 1)) begin
      w_ptr_next = {IW{1'b0}};
    end else begin
      w_ptr_next = r_grant + IW'(1);
    end
  end

  // Sequencer: issue, arm (stale done ignored), wait with watchdog, one-cycle response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_ptr        <= {IW{1'b0}};
      r_grant      <= {IW{1'b0}};
      r_wd         <= {WDW{1'b0}};
      tx_ack       <= {NUM_REQ{1'b0}};
      tx_error     <= 1'b0;
      tx_result    <= {WIDTH{1'b0}};
      tx_sub_start <= 1'b0;
      tx_sub_a     <= {WIDTH{1'b0}};
      tx_sub_b     <= {WIDTH{1'b0}};
      tx_sub_p     <= {WIDTH{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant      <= w_winner;
            tx_sub_a     <= rx_a[w_winner*WIDTH +: WIDTH];
            tx_sub_b     <= rx_b[w_winner*WIDTH +: WIDTH];
            tx_sub_p     <= rx_p;
            tx_sub_start <= 1'b1;
            r_state      <= ST_ISSUE;
          end else begin
            r_state      <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          tx_sub_start <= 1'b0;
          r_state      <= ST_ARM;
        end
        ST_ARM: begin
          r_wd    <= {WDW{1'b0}};
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (rx_sub_done) begin
            tx_result <= rx_sub_result;
            tx_ack    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << r_grant;
            tx_error  <= 1'b0;
            r_state   <= ST_RESP;
          end else begin
            r_wd <= w_wd_next;
            if (w_timeout) begin
              tx_result <= {WIDTH{1'b0}};
              tx_ack    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << r_grant;
              tx_error  <= 1'b1;
              r_state   <= ST_RESP;
            end else begin
              r_state   <= ST_WAIT;
            end
          end
        end
        ST_RESP: begin
          tx_ack   <= {NUM_REQ{1'b0}};
          tx_error <= 1'b0;
          r_ptr    <= w_ptr_next;
          r_state  <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ff_sub_arbiter.sv
// Directed bench for ff_sub_arbiter with a two-cycle subtractor model that can be told to hang.
module tb_ff_sub_arbiter;
  localparam int N = 4;
  localparam int W = 256;
  localparam int TO = 15;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [N-1:0]     rx_req;
  logic [N*W-1:0]   rx_a, rx_b;
  logic [W-1:0]     rx_p;
  logic [N-1:0]     tx_ack;
  logic             tx_error;
  logic [W-1:0]     tx_result;
  logic             tx_sub_start;
  logic [W-1:0]     tx_sub_a, tx_sub_b, tx_sub_p;
  logic             sub_done;
  logic [W-1:0]     sub_res;
  logic             sub_cnt;
  logic             hang;

  int n_checks = 0;
  int n_err = 0;
  int multi_ack = 0;
  int wide_start = 0;
  int ack3_cnt = 0;
  int ack3_snap;
  logic prev_start = 1'b0;

  ff_sub_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .rx_req(rx_req), .rx_a(rx_a), .rx_b(rx_b), .rx_p(rx_p),
    .tx_ack(tx_ack), .tx_error(tx_error), .tx_result(tx_result), .tx_sub_start(tx_sub_start),
    .tx_sub_a(tx_sub_a), .tx_sub_b(tx_sub_b), .tx_sub_p(tx_sub_p),
    .rx_sub_done(sub_done), .rx_sub_result(sub_res)
  );

  always #5 clk = ~clk;

  // Subtractor model: load on start, done two edges later unless hung.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sub_done <= 1'b0;
      sub_cnt  <= 1'b0;
      sub_res  <= '0;
    end else if (tx_sub_start) begin
      sub_cnt  <= 1'b1;
      sub_done <= 1'b0;
      sub_res  <= (tx_sub_a >= tx_sub_b) ? tx_sub_a - tx_sub_b : tx_sub_a - tx_sub_b + tx_sub_p;
    end else if (sub_cnt) begin
      sub_cnt  <= 1'b0;
      sub_done <= !hang;
    end
  end

  // Protocol monitor: ack one-hot, start one cycle wide, count acks to requester 3.
  always @(posedge clk) begin
    if ($countones(tx_ack) > 1) multi_ack++;
    if (tx_ack[3]) ack3_cnt++;
    if (prev_start && tx_sub_start) wide_start++;
    prev_start = tx_sub_start;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    rx_a[i*W +: W] = a;
    rx_b[i*W +: W] = b;
  endtask

  initial begin
    reset_n = 1'b0; rx_req = '0; rx_a = '0; rx_b = '0; rx_p = '0; hang = 1'b0;
    tick(); tick();
    chk("rst_ack", W'(tx_ack), W'(0));
    chk("rst_err", W'(tx_error), W'(0));
    chk("rst_result", tx_result, W'(0));
    chk("rst_start", W'(tx_sub_start), W'(0));
    chk("rst_sub_a", tx_sub_a, W'(0));
    chk("rst_sub_p", tx_sub_p, W'(0));
    reset_n = 1'b1;
    tick();
    chk("idle_ack", W'(tx_ack), W'(0));

    // Fairness: all four held, acks 0,1,2,3,0 five cycles apart.
    rx_p = W'(97);
    for (int i = 0; i < N; i++) set_op(i, W'(20 + i), W'(2 * i));
    rx_req = 4'hF;
    tick();
    chk("fair_start", W'(tx_sub_start), W'(1));
    chk("fair_sub_a", tx_sub_a, W'(20));
    tick(); tick(); tick();
    for (int j = 0; j < 5; j++) begin
      chk($sformatf("fair_ack%0d", j), W'(tx_ack), W'(4'b0001 << (j % 4)));
      chk($sformatf("fair_res%0d", j), tx_result, W'(20 - (j % 4)));
      if (j < 4) begin
        for (int k = 0; k < 4; k++) begin
          tick();
          chk($sformatf("fair_gap%0d_%0d", j, k), W'(tx_ack), W'(0));
        end
        tick();
      end
    end
    rx_req = '0;
    tick();
    chk("fair_end_ack", W'(tx_ack), W'(0));

    // Single request: 5-3 mod 7.
    rx_p = W'(7);
    set_op(0, W'(5), W'(3));
    rx_req = 4'b0001;
    tick();
    chk("single_start", W'(tx_sub_start), W'(1));
    chk("single_sub_a", tx_sub_a, W'(5));
    chk("single_sub_b", tx_sub_b, W'(3));
    chk("single_sub_p", tx_sub_p, W'(7));
    tick();
    chk("single_start_drop", W'(tx_sub_start), W'(0));
    tick();
    chk("single_ack_early", W'(tx_ack), W'(0));
    tick();
    chk("single_ack", W'(tx_ack), W'(4'b0001));
    chk("single_res", tx_result, W'(2));
    chk("single_err", W'(tx_error), W'(0));
    rx_req = '0;
    tick();
    chk("single_ack_drop", W'(tx_ack), W'(0));
    chk("single_res_hold", tx_result, W'(2));

    // Borrow: 3-5 mod 7 = 5.
    set_op(2, W'(3), W'(5));
    rx_req = 4'b0100;
    repeat (4) tick();
    chk("borrow_ack", W'(tx_ack), W'(4'b0100));
    chk("borrow_res", tx_result, W'(5));
    chk("borrow_err", W'(tx_error), W'(0));
    rx_req = '0;
    tick();

    // Wrap: pointer at 3, requests 0 and 1 -> 0 first, then 1.
    ack3_snap = ack3_cnt;
    set_op(0, W'(5), W'(3));
    set_op(1, W'(6), W'(2));
    rx_req = 4'b0011;
    repeat (4) tick();
    chk("wrap_ack0", W'(tx_ack), W'(4'b0001));
    chk("wrap_res0", tx_result, W'(2));
    rx_req = 4'b0010;
    tick();
    chk("wrap_gap", W'(tx_ack), W'(0));
    repeat (4) tick();
    chk("wrap_ack1", W'(tx_ack), W'(4'b0010));
    chk("wrap_res1", tx_result, W'(4));
    rx_req = '0;
    tick();
    chk("wrap_no_ack3", W'(ack3_cnt), W'(ack3_snap));

    // Watchdog: subtractor hangs, error ack TIMEOUT cycles after ARM.
    hang = 1'b1;
    rx_p = W'(11);
    set_op(3, W'(9), W'(4));
    rx_req = 4'b1000;
    tick();
    chk("wd_start", W'(tx_sub_start), W'(1));
    repeat (16) tick();
    chk("wd_ack_early", W'(tx_ack), W'(0));
    tick();
    chk("wd_ack", W'(tx_ack), W'(4'b1000));
    chk("wd_err", W'(tx_error), W'(1));
    chk("wd_res", tx_result, W'(0));
    rx_req = '0;
    hang = 1'b0;
    tick();
    chk("wd_ack_drop", W'(tx_ack), W'(0));
    chk("wd_err_drop", W'(tx_error), W'(0));
    set_op(1, W'(8), W'(3));
    rx_req = 4'b0010;
    repeat (4) tick();
    chk("post_wd_ack", W'(tx_ack), W'(4'b0010));
    chk("post_wd_res", tx_result, W'(5));
    chk("post_wd_err", W'(tx_error), W'(0));
    rx_req = '0;
    tick();

    // Reset during WAIT: pointer at 2 grants 3; after reset pointer 0 grants 1.
    hang = 1'b1;
    rx_req = 4'b1010;
    repeat (3) tick();
    chk("mid_sub_a", tx_sub_a, W'(9));
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ack", W'(tx_ack), W'(0));
    chk("mid_rst_res", tx_result, W'(0));
    chk("mid_rst_start", W'(tx_sub_start), W'(0));
    chk("mid_rst_sub_a", tx_sub_a, W'(0));
    chk("mid_rst_sub_p", tx_sub_p, W'(0));
    set_op(1, W'(10), W'(4));
    hang = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    chk("mid_re_start", W'(tx_sub_start), W'(1));
    chk("mid_re_sub_a", tx_sub_a, W'(10));
    repeat (3) tick();
    chk("mid_re_ack1", W'(tx_ack), W'(4'b0010));
    chk("mid_re_res1", tx_result, W'(6));
    rx_req = 4'b1000;
    tick();
    chk("mid_re_gap", W'(tx_ack), W'(0));
    repeat (4) tick();
    chk("mid_re_ack3", W'(tx_ack), W'(4'b1000));
    chk("mid_re_res3", tx_result, W'(5));
    rx_req = '0;
    tick();

    chk("mon_multi_ack", W'(multi_ack), W'(0));
    chk("mon_wide_start", W'(wide_start), W'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
